// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 memory / writeback stage.
package legv8_mem_pkg;

  localparam int DEF_DATA_BITS = 64;
  // The byte address is turned into a doubleword index by dropping 3 low bits.
  localparam int DWORD_SHIFT   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: issues one req/ack transaction per memory op,
// holds the request fields stable while BUSY, aborts after TIMEOUT_CYCLES
// BUSY cycles without an ack, and tells the pipeline when to freeze.
module mem_req_fsm
  import legv8_mem_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 ack_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_BITS-1:0] dmem_addr_o,
  output logic [DATA_BITS-1:0] dmem_wdata_o,
  output logic                 stall_o,
  output logic                 abort_o,
  output logic                 timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 tout_q, tout_d;
  logic                 hit, done;

  // Completion decode: an ack always wins over a simultaneous timeout.
  always_comb begin
    hit     = (state_q == BUSY) && (cnt_q == CNT_LAST);
    done    = (state_q == BUSY) && (ack_i || hit);
    abort_o = (state_q == BUSY) && !ack_i && hit;
    stall_o = acc_i && !done;
  end

  // Next-state: launch in IDLE, count wait cycles in BUSY, return on ack/abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_i) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      BUSY: begin
        if (ack_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
        end else if (hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          tout_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset drops an in-flight request at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tout_q  <= tout_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign timeout_o    = tout_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register for the LEGv8 core.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned accesses are
// not issued; they retire with RegWrite_W=0 and pulse misalign_fault.
module mem_wb_stage
  import legv8_mem_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] ALUResult_M,
  input  logic [DATA_BITS-1:0] ReadData2_M,
  input  logic                 RegWrite_M,
  input  logic                 MemToReg_M,
  input  logic                 MemRead_M,
  input  logic                 MemWrite_M,
  input  logic [4:0]           DestinationReg_M,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_BITS-1:0] dmem_addr,
  output logic [DATA_BITS-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [DATA_BITS-1:0] dmem_rdata,
  output logic                 stall_M,
  output logic [DATA_BITS-1:0] Result_W,
  output logic                 RegWrite_W,
  output logic [4:0]           DestinationReg_W,
  output logic                 dmem_timeout,
  output logic                 misalign_fault
);

  logic acc, misal, acc_ok, abort;

  assign acc = MemRead_M | MemWrite_M;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = acc & (ALUResult_M[DWORD_SHIFT-1:0] != '0);
`else
  assign misal = 1'b0;
`endif

  // A trapped access never reaches the sequencer, so it cannot stall.
  assign acc_ok = acc & ~misal;

  mem_req_fsm #(
    .DATA_BITS     (DATA_BITS),
    .ADDR_BITS     (ADDR_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .acc_i       (acc_ok),
    .we_i        (MemWrite_M),
    .addr_i      (ALUResult_M[ADDR_BITS+DWORD_SHIFT-1:DWORD_SHIFT]),
    .wdata_i     (ReadData2_M),
    .ack_i       (dmem_ack),
    .dmem_req_o  (dmem_req),
    .dmem_we_o   (dmem_we),
    .dmem_addr_o (dmem_addr),
    .dmem_wdata_o(dmem_wdata),
    .stall_o     (stall_M),
    .abort_o     (abort),
    .timeout_o   (dmem_timeout)
  );

  logic [DATA_BITS-1:0] result_q, result_d;
  logic                 regwrite_q, regwrite_d;
  logic [4:0]           dest_q, dest_d;

  // MEM/WB next value: hold while stalled; aborted or trapped ops never write.
  always_comb begin
    result_d   = result_q;
    regwrite_d = regwrite_q;
    dest_d     = dest_q;
    if (!stall_M) begin
      result_d   = MemToReg_M ? dmem_rdata : ALUResult_M;
      regwrite_d = RegWrite_M & ~abort & ~misal;
      dest_d     = DestinationReg_M;
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q   <= '0;
      regwrite_q <= 1'b0;
      dest_q     <= '0;
    end else begin
      result_q   <= result_d;
      regwrite_q <= regwrite_d;
      dest_q     <= dest_d;
    end
  end

  assign Result_W         = result_q;
  assign RegWrite_W       = regwrite_q;
  assign DestinationReg_W = dest_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  // One-cycle fault pulse for each trapped access.
  always_ff @(posedge clk) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= misal;
  end

  assign misalign_fault = misalign_q;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: reset check, table of single-cycle ops, directed
// memory sequences and random ops against a latency/memory reference model.
module tb_mem_wb_stage;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ALUResult_M, ReadData2_M, dmem_rdata;
  logic          RegWrite_M, MemToReg_M, MemRead_M, MemWrite_M, dmem_ack;
  logic [4:0]    DestinationReg_M;
  logic          dmem_req, dmem_we, stall_M, RegWrite_W, dmem_timeout, misalign_fault;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, Result_W;
  logic [4:0]    DestinationReg_W;

  int n_chk  = 0;
  int n_fail = 0;

  mem_wb_stage #(.DATA_BITS(DW), .ADDR_BITS(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_M(ALUResult_M), .ReadData2_M(ReadData2_M),
    .RegWrite_M(RegWrite_M), .MemToReg_M(MemToReg_M),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .DestinationReg_M(DestinationReg_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_M(stall_M), .Result_W(Result_W), .RegWrite_W(RegWrite_W),
    .DestinationReg_W(DestinationReg_W), .dmem_timeout(dmem_timeout),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ALUResult_M = '0; ReadData2_M = '0; RegWrite_M = 0; MemToReg_M = 0;
    MemRead_M = 0; MemWrite_M = 0; DestinationReg_M = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  // Reference memory behind the data port (indices 0..15 used by random ops).
  logic [DW-1:0] mdl [0:15];

  // Apply one instruction and check it through retirement.
  // w = number of wait cycles before ack; w >= TO means the ack never comes.
  task automatic do_op(input string nm, input bit rd, input bit wr,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input bit rw, input bit mtr, input logic [4:0] dst,
                       input int w, input logic [DW-1:0] rdv);
    bit mem, misal, to, fin;
    logic [DW-1:0] used_rd;
    logic [AW-1:0] idx;
    mem   = rd | wr;
`ifdef MEM_MISALIGN_TRAP_EN
    misal = mem && (alu[2:0] != 3'd0);
`else
    misal = 0;
`endif
    idx = alu[AW+2:3];
    ALUResult_M = alu; ReadData2_M = sd; RegWrite_M = rw; MemToReg_M = mtr;
    MemRead_M = rd; MemWrite_M = wr; DestinationReg_M = dst;
    dmem_ack = 0; dmem_rdata = rdv;
    if (!mem || misal) begin
      @(negedge clk);
      chk({nm, "/stall"}, stall_M, 0);
      @(posedge clk); #1;
      chk({nm, "/req"}, dmem_req, 0);
      chk({nm, "/res"}, Result_W, mtr ? rdv : alu);
      chk({nm, "/rw"}, RegWrite_W, rw & !misal);
      chk({nm, "/dst"}, DestinationReg_W, dst);
      chk({nm, "/misal"}, misalign_fault, misal);
    end else begin
      @(negedge clk);
      chk({nm, "/stall_idle"}, stall_M, 1);
      chk({nm, "/req_idle"}, dmem_req, 0);
      @(posedge clk); #1;
      to = 0; fin = 0; used_rd = rdv;
      for (int b = 0; b < TO && !fin; b++) begin
        dmem_ack   = (b == w);
        dmem_rdata = (b == w) ? rdv : {$urandom(), $urandom()};
        fin = dmem_ack || (b == TO - 1);
        @(negedge clk);
        chk({nm, "/req"}, dmem_req, 1);
        chk({nm, "/we"}, dmem_we, wr);
        chk({nm, "/addr"}, dmem_addr, idx);
        chk({nm, "/wdata"}, dmem_wdata, sd);
        chk({nm, "/stall_busy"}, stall_M, !fin);
        if (b > 0) chk({nm, "/tout_busy"}, dmem_timeout, 0);
        used_rd = dmem_rdata;
        to = !dmem_ack && (b == TO - 1);
        @(posedge clk); #1;
      end
      dmem_ack = 0;
      chk({nm, "/req_end"}, dmem_req, 0);
      chk({nm, "/res"}, Result_W, mtr ? used_rd : alu);
      chk({nm, "/rw"}, RegWrite_W, rw & !to);
      chk({nm, "/dst"}, DestinationReg_W, dst);
      chk({nm, "/tout"}, dmem_timeout, to);
      chk({nm, "/misal"}, misalign_fault, 0);
      if (wr && !to && idx < 16) mdl[idx[3:0]] = sd;
    end
  endtask

  typedef struct {
    logic [DW-1:0] alu;
    logic          rw;
    logic [4:0]    dst;
    logic [DW-1:0] exp_res;
    logic          exp_rw;
    logic [4:0]    exp_dst;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [DW-1:0] a, d;
    int idx, w, kind;

    for (int i = 0; i < 16; i++) mdl[i] = '0;

    vecs[0] = '{64'h2A, 1'b1, 5'd3, 64'h2A, 1'b1, 5'd3};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 5'd7, 64'h1234_5678_9ABC_DEF0, 1'b0, 5'd7};
    vecs[3] = '{64'h0, 1'b1, 5'd0, 64'h0, 1'b1, 5'd0};
    vecs[4] = '{64'h8000_0000_0000_0001, 1'b1, 5'd16, 64'h8000_0000_0000_0001, 1'b1, 5'd16};

    // Reset: drive garbage on the inputs to show reset dominates.
    reset = 0;
    idle_inputs();
    ALUResult_M = 64'h40; MemRead_M = 1; RegWrite_M = 1; DestinationReg_M = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    chk("rst/req", dmem_req, 0);
    chk("rst/we", dmem_we, 0);
    chk("rst/addr", dmem_addr, 0);
    chk("rst/wdata", dmem_wdata, 0);
    chk("rst/res", Result_W, 0);
    chk("rst/rw", RegWrite_W, 0);
    chk("rst/dst", DestinationReg_W, 0);
    chk("rst/tout", dmem_timeout, 0);
    chk("rst/misal", misalign_fault, 0);
    reset = 1;
    @(posedge clk); #1;

    // Table of single-cycle ALU ops.
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      ALUResult_M = vecs[i].alu; RegWrite_M = vecs[i].rw; DestinationReg_M = vecs[i].dst;
      @(negedge clk);
      chk($sformatf("vec%0d/stall", i), stall_M, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d/res", i), Result_W, vecs[i].exp_res);
      chk($sformatf("vec%0d/rw", i), RegWrite_W, vecs[i].exp_rw);
      chk($sformatf("vec%0d/dst", i), DestinationReg_W, vecs[i].exp_dst);
    end

    // Zero-wait load, 3-wait store, timeout, ack on the timeout cycle.
    do_op("ldur", 1, 0, 64'h40, 64'h0, 1, 1, 5'd4, 0, 64'hDEAD);
    do_op("stur", 0, 1, 64'h18, 64'h55, 0, 0, 5'd0, 3, 64'h0);
    do_op("ld_to", 1, 0, 64'h100, 64'h0, 1, 1, 5'd6, TO + 5, 64'h0);
    idle_inputs();
    @(posedge clk); #1;
    chk("ld_to/pulse_end", dmem_timeout, 0);
    do_op("ld_ackwins", 1, 0, 64'h28, 64'h77, 1, 1, 5'd8, TO - 1, 64'hCAFE_F00D);

    // Reset in the second BUSY cycle, late ack afterwards.
    idle_inputs();
    ALUResult_M = 64'h80; ReadData2_M = 64'h77; MemRead_M = 1; MemToReg_M = 1;
    RegWrite_M = 1; DestinationReg_M = 5'd12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    idle_inputs();
    @(negedge clk);
    chk("midrst/req_before", dmem_req, 1);
    @(posedge clk); #1;
    chk("midrst/req", dmem_req, 0);
    chk("midrst/addr", dmem_addr, 0);
    chk("midrst/wdata", dmem_wdata, 0);
    chk("midrst/res", Result_W, 0);
    chk("midrst/rw", RegWrite_W, 0);
    chk("midrst/dst", DestinationReg_W, 0);
    reset = 1;
    dmem_ack = 1; dmem_rdata = 64'hBEEF;
    @(negedge clk);
    chk("midrst/stall", stall_M, 0);
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("midrst/req_late", dmem_req, 0);
    chk("midrst/res_late", Result_W, 0);
    chk("midrst/rw_late", RegWrite_W, 0);
    chk("midrst/tout_late", dmem_timeout, 0);

    // Misaligned load: trapped with the macro, low bits dropped without it.
    do_op("misal", 1, 0, 64'h44, 64'h0, 1, 1, 5'd5, 0, 64'h1111);
    idle_inputs();
    @(posedge clk); #1;
    chk("misal/pulse_end", misalign_fault, 0);

    // Random ops against the reference memory and latency model.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 15);
      a = {$urandom(), $urandom()};
      a[AW+2:3] = AW'(idx);
`ifdef MEM_MISALIGN_TRAP_EN
      a[2:0] = 3'd0;
`endif
      d = {$urandom(), $urandom()};
      w = ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
      case (kind)
        0: do_op($sformatf("rnd%0d/alu", n), 0, 0, a, d, 1'($urandom()), 0,
                 5'($urandom()), 0, 64'h0);
        1: do_op($sformatf("rnd%0d/ld", n), 1, 0, a, d, 1, 1, 5'($urandom()), w,
                 mdl[idx]);
        default: do_op($sformatf("rnd%0d/st", n), 0, 1, a, d, 0, 0, 5'd0, w, 64'h0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
